// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_arb_pkg: shared widths, opcodes and request types for alu_arbiter
// Rev 1.0
// ------------------------------------------------------------------
package alu_arb_pkg;

  localparam int ALU_OP_W  = 4;
  localparam int NUM_PORTS = 2;
  localparam int DATA_W    = 32;
  localparam int ALU_TAG_W = 4;

  localparam logic [ALU_OP_W-1:0] ADD  = 4'd0;
  localparam logic [ALU_OP_W-1:0] SUB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] SLL  = 4'd2;
  localparam logic [ALU_OP_W-1:0] SLT  = 4'd3;
  localparam logic [ALU_OP_W-1:0] SLTU = 4'd4;
  localparam logic [ALU_OP_W-1:0] XOR  = 4'd5;
  localparam logic [ALU_OP_W-1:0] SRL  = 4'd6;
  localparam logic [ALU_OP_W-1:0] SRA  = 4'd7;
  localparam logic [ALU_OP_W-1:0] OR   = 4'd8;
  localparam logic [ALU_OP_W-1:0] AND  = 4'd9;

  typedef struct packed {
    logic [DATA_W-1:0]    operand_a;
    logic [DATA_W-1:0]    operand_b;
    logic [ALU_OP_W-1:0]  alu_op;
    logic [ALU_TAG_W-1:0] tag;
  } alu_req_t;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_arbiter_if: per-port request/response channels of alu_arbiter
// Rev 1.0
// ------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int TAG_W = 4
);
  import alu_arb_pkg::*;

  logic [NUM_PORTS-1:0]              i_req_valid;
  logic [NUM_PORTS-1:0]              o_req_ready;
  logic [NUM_PORTS-1:0][DATA_W-1:0]   i_req_operand_a;
  logic [NUM_PORTS-1:0][DATA_W-1:0]   i_req_operand_b;
  logic [NUM_PORTS-1:0][ALU_OP_W-1:0] i_req_alu_op;
  logic [NUM_PORTS-1:0][TAG_W-1:0]    i_req_tag;
  logic [NUM_PORTS-1:0]              o_rsp_valid;
  logic [NUM_PORTS-1:0]              i_rsp_ready;
  logic [NUM_PORTS-1:0][DATA_W-1:0]   o_rsp_data;
  logic [NUM_PORTS-1:0][TAG_W-1:0]    o_rsp_tag;

  modport master (
    output i_req_valid, i_req_operand_a, i_req_operand_b, i_req_alu_op, i_req_tag, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_tag
  );

  modport slave (
    input  i_req_valid, i_req_operand_a, i_req_operand_b, i_req_alu_op, i_req_tag, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_tag
  );

endinterface
`default_nettype wire

// File: rtl/alu_arb_rsp_slot.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_arb_rsp_slot: one-entry response buffer (EMPTY/FULL) for one port
// Rev 1.0
// ------------------------------------------------------------------
module alu_arb_rsp_slot
  import alu_arb_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  wire logic              i_clk,
  input  wire logic              i_rst_n,
  input  wire logic              i_load,
  input  wire logic [DATA_W-1:0] i_data,
  input  wire logic [TAG_W-1:0]  i_tag,
  input  wire logic              i_rsp_ready,
  output logic                   o_rsp_valid,
  output logic [DATA_W-1:0]      o_rsp_data,
  output logic [TAG_W-1:0]       o_rsp_tag,
  output logic                   o_can_accept
);

  slot_state_e       r_state;
  slot_state_e       w_state_nxt;
  logic [DATA_W-1:0] r_data;
  logic [TAG_W-1:0]  r_tag;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= SLOT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A full slot can take a new result only in the cycle it is being popped
  always_comb begin
    w_state_nxt  = r_state;
    o_can_accept = 1'b0;
    case (r_state)
      SLOT_EMPTY: begin
        o_can_accept = 1'b1;
        if (i_load) w_state_nxt = SLOT_FULL;
      end
      SLOT_FULL: begin
        o_can_accept = i_rsp_ready;
        if (!i_load && i_rsp_ready) w_state_nxt = SLOT_EMPTY;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= '0;
      r_tag  <= '0;
    end else if (i_load) begin
      r_data <= i_data;
      r_tag  <= i_tag;
    end
  end

  assign o_rsp_valid = (r_state == SLOT_FULL);
  assign o_rsp_data  = r_data;
  assign o_rsp_tag   = r_tag;

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_arbiter: shares one combinational ALU between two requesters, round-robin
// (fixed priority to port 0 when ALU_ARB_FIXED_PRIO_EN is defined). Rev 1.0
// ------------------------------------------------------------------
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int TAG_W = ALU_TAG_W
) (
  input  wire logic                i_clk,
  input  wire logic                i_rst_n,
  alu_arbiter_if.slave             bus,
  output logic [DATA_W-1:0]        o_alu_operand_a,
  output logic [DATA_W-1:0]        o_alu_operand_b,
  output logic [ALU_OP_W-1:0]      o_alu_op,
  input  wire logic [DATA_W-1:0]   i_alu_data
);

  logic                              r_active;
  logic [NUM_PORTS-1:0]              w_can_accept;
  logic [NUM_PORTS-1:0]              w_elig;
  logic [NUM_PORTS-1:0]              w_grant;
  logic [NUM_PORTS-1:0]              w_rsp_valid;
  logic [NUM_PORTS-1:0][DATA_W-1:0]  w_rsp_data;
  logic [NUM_PORTS-1:0][TAG_W-1:0]   w_rsp_tag;
  alu_req_t                          w_sel;

  // Keeps o_req_ready low while reset is held and for the release cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
    end
  end

  assign w_elig = bus.i_req_valid & w_can_accept & {NUM_PORTS{r_active}};

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    w_grant = '0;
    if (w_elig[0]) begin
      w_grant = 2'b01;
    end else if (w_elig[1]) begin
      w_grant = 2'b10;
    end
  end
`else
  logic r_last_grant;

  always_comb begin
    w_grant = w_elig;
    if (&w_elig) w_grant = r_last_grant ? 2'b01 : 2'b10;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= 1'b1;
    end else if (|w_grant) begin
      r_last_grant <= w_grant[1];
    end
  end
`endif

  always_comb begin
    w_sel = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_grant[p]) begin
        w_sel.operand_a = bus.i_req_operand_a[p];
        w_sel.operand_b = bus.i_req_operand_b[p];
        w_sel.alu_op    = bus.i_req_alu_op[p];
        w_sel.tag       = ALU_TAG_W'(bus.i_req_tag[p]);
      end
    end
  end

  assign o_alu_operand_a = w_sel.operand_a;
  assign o_alu_operand_b = w_sel.operand_b;
  assign o_alu_op        = w_sel.alu_op;
  assign bus.o_req_ready = w_grant;

  generate
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_slot
      alu_arb_rsp_slot #(.TAG_W(TAG_W)) u_slot (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load       (w_grant[g]),
        .i_data       (i_alu_data),
        .i_tag        (w_sel.tag[TAG_W-1:0]),
        .i_rsp_ready  (bus.i_rsp_ready[g]),
        .o_rsp_valid  (w_rsp_valid[g]),
        .o_rsp_data   (w_rsp_data[g]),
        .o_rsp_tag    (w_rsp_tag[g]),
        .o_can_accept (w_can_accept[g])
      );
    end
  endgenerate

  assign bus.o_rsp_valid = w_rsp_valid;
  assign bus.o_rsp_data  = w_rsp_data;
  assign bus.o_rsp_tag   = w_rsp_tag;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_alu_arbiter: directed and randomized self-checking bench for alu_arbiter
// Rev 1.0
// ------------------------------------------------------------------
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int TAG_W = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_a, alu_b, alu_data;
  logic [3:0]  alu_op;
  int          n_checks = 0;
  int          n_pass   = 0;

  // Reference model of the response slots and arbitration pointer
  logic        m_valid [2];
  logic [31:0] m_data  [2];
  logic [3:0]  m_tag   [2];
  int          m_last;

  always #5 clk = ~clk;

  alu_arbiter_if #(.TAG_W(TAG_W)) bus ();

  alu_arbiter #(.TAG_W(TAG_W)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .bus             (bus),
    .o_alu_operand_a (alu_a),
    .o_alu_operand_b (alu_b),
    .o_alu_op        (alu_op),
    .i_alu_data      (alu_data)
  );

  function automatic logic [31:0] alu_ref(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      SLL:     return a << b[4:0];
      SLT:     return {31'd0, $signed(a) < $signed(b)};
      SLTU:    return {31'd0, a < b};
      XOR:     return a ^ b;
      SRL:     return a >> b[4:0];
      SRA:     return $unsigned($signed(a) >>> b[4:0]);
      OR:      return a | b;
      AND:     return a & b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_data = alu_ref(alu_op, alu_a, alu_b);

  function automatic logic [1:0] model_grant(logic [1:0] v, logic [1:0] rr);
    logic [1:0] e;
    for (int p = 0; p < 2; p++) e[p] = v[p] && (!m_valid[p] || rr[p]);
    if (e == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 2'b01;
`else
      return (m_last == 1) ? 2'b01 : 2'b10;
`endif
    end
    return e;
  endfunction

  task automatic idle_inputs();
    bus.i_req_valid     = 2'b00;
    bus.i_rsp_ready     = 2'b00;
    bus.i_req_operand_a = '0;
    bus.i_req_operand_b = '0;
    bus.i_req_alu_op    = '0;
    bus.i_req_tag       = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) m_valid[p] = 1'b0;
    m_last = 1;
  endtask

  task automatic set_req(input int p, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag);
    bus.i_req_valid[p]     = 1'b1;
    bus.i_req_alu_op[p]    = op;
    bus.i_req_operand_a[p] = a;
    bus.i_req_operand_b[p] = b;
    bus.i_req_tag[p]       = tag;
  endtask

  task automatic set_rand_req(input int p);
    set_req(p, 4'($urandom_range(0, 15)), $urandom, $urandom, 4'($urandom_range(0, 15)));
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    bus.i_req_valid = 2'b11;
    #3;
    n_checks++; if (bus.o_rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid actual=%b expected=00", bus.o_rsp_valid); else n_pass++;
    n_checks++; if (bus.o_rsp_data !== '0) $display("FAIL reset_rsp_data actual=%h expected=0", bus.o_rsp_data); else n_pass++;
    n_checks++; if (bus.o_rsp_tag !== '0) $display("FAIL reset_rsp_tag actual=%h expected=0", bus.o_rsp_tag); else n_pass++;
    n_checks++; if (bus.o_req_ready !== 2'b00) $display("FAIL reset_req_ready actual=%b expected=00", bus.o_req_ready); else n_pass++;
    n_checks++; if ({alu_a, alu_b, alu_op} !== '0) $display("FAIL reset_alu_out actual=%h expected=0", {alu_a, alu_b, alu_op}); else n_pass++;
    do_reset();
  endtask

  task automatic test_single_add();
    do_reset();
    bus.i_rsp_ready = 2'b11;
    set_req(0, ADD, 32'd5, 32'd7, 4'd3);
    @(negedge clk);
    n_checks++; if (bus.o_req_ready !== 2'b01) $display("FAIL add_ready actual=%b expected=01", bus.o_req_ready); else n_pass++;
    n_checks++; if ({alu_a, alu_b, alu_op} !== {32'd5, 32'd7, ADD}) $display("FAIL add_alu_drive actual=%h expected=%h", {alu_a, alu_b, alu_op}, {32'd5, 32'd7, ADD}); else n_pass++;
    @(posedge clk); #1;
    bus.i_req_valid = 2'b00;
    @(negedge clk);
    n_checks++; if ({bus.o_rsp_valid[0], bus.o_rsp_data[0], bus.o_rsp_tag[0]} !== {1'b1, 32'd12, 4'd3})
      $display("FAIL add_rsp actual=%h expected=%h", {bus.o_rsp_valid[0], bus.o_rsp_data[0], bus.o_rsp_tag[0]}, {1'b1, 32'd12, 4'd3}); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp;
    logic [31:0] exp_data;
    logic [3:0]  exp_tag;
    int          gp;
    do_reset();
    bus.i_rsp_ready = 2'b11;
    for (int p = 0; p < 2; p++) set_rand_req(p);
    for (int c = 0; c < 8; c++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp = 2'b01;
`else
      exp = (c % 2 == 1) ? 2'b10 : 2'b01;
`endif
      @(negedge clk);
      n_checks++; if (bus.o_req_ready !== exp) $display("FAIL rr_grant cycle=%0d actual=%b expected=%b", c, bus.o_req_ready, exp); else n_pass++;
      gp       = exp[1] ? 1 : 0;
      exp_data = alu_ref(bus.i_req_alu_op[gp], bus.i_req_operand_a[gp], bus.i_req_operand_b[gp]);
      exp_tag  = bus.i_req_tag[gp];
      @(posedge clk); #1;
      n_checks++; if ({bus.o_rsp_valid[gp], bus.o_rsp_data[gp], bus.o_rsp_tag[gp]} !== {1'b1, exp_data, exp_tag})
        $display("FAIL rr_rsp port=%0d actual=%h expected=%h", gp, {bus.o_rsp_valid[gp], bus.o_rsp_data[gp], bus.o_rsp_tag[gp]}, {1'b1, exp_data, exp_tag}); else n_pass++;
      set_rand_req(gp);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(0, SRA, 32'h8000_0000, 32'd4, 4'd1);
    @(negedge clk);
    n_checks++; if (bus.o_req_ready !== 2'b01) $display("FAIL bp_first_ready actual=%b expected=01", bus.o_req_ready); else n_pass++;
    @(posedge clk); #1;
    set_req(0, SLTU, 32'hFFFF_FFFF, 32'd1, 4'd2);
    set_req(1, SLT, 32'hFFFF_FFFF, 32'd1, 4'd5);
    @(negedge clk);
    n_checks++; if ({bus.o_rsp_valid[0], bus.o_rsp_data[0]} !== {1'b1, 32'hF800_0000}) $display("FAIL bp_sra_rsp actual=%h expected=1f8000000", {bus.o_rsp_valid[0], bus.o_rsp_data[0]}); else n_pass++;
    n_checks++; if (bus.o_req_ready !== 2'b10) $display("FAIL bp_port1_ready actual=%b expected=10", bus.o_req_ready); else n_pass++;
    @(posedge clk); #1;
    bus.i_req_valid[1] = 1'b0;
    @(negedge clk);
    n_checks++; if ({bus.o_rsp_valid[0], bus.o_rsp_data[0], bus.o_rsp_tag[0]} !== {1'b1, 32'hF800_0000, 4'd1}) $display("FAIL bp_sra_hold actual=%h expected=1f80000001", {bus.o_rsp_valid[0], bus.o_rsp_data[0], bus.o_rsp_tag[0]}); else n_pass++;
    n_checks++; if ({bus.o_rsp_valid[1], bus.o_rsp_data[1], bus.o_rsp_tag[1]} !== {1'b1, 32'd1, 4'd5}) $display("FAIL bp_slt_rsp actual=%h expected=1000000015", {bus.o_rsp_valid[1], bus.o_rsp_data[1], bus.o_rsp_tag[1]}); else n_pass++;
    n_checks++; if (bus.o_req_ready !== 2'b00) $display("FAIL bp_blocked_ready actual=%b expected=00", bus.o_req_ready); else n_pass++;
    bus.i_rsp_ready = 2'b01;
    #1;
    n_checks++; if (bus.o_req_ready !== 2'b01) $display("FAIL bp_pop_refill_ready actual=%b expected=01", bus.o_req_ready); else n_pass++;
    @(posedge clk); #1;
    bus.i_req_valid = 2'b00;
    bus.i_rsp_ready = 2'b00;
    @(negedge clk);
    n_checks++; if ({bus.o_rsp_valid[0], bus.o_rsp_data[0], bus.o_rsp_tag[0]} !== {1'b1, 32'd0, 4'd2}) $display("FAIL bp_sltu_rsp actual=%h expected=1000000002", {bus.o_rsp_valid[0], bus.o_rsp_data[0], bus.o_rsp_tag[0]}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.i_rsp_ready = 2'b01;
    set_req(0, SUB, 32'd10, 32'd3, 4'd4);
    @(negedge clk);
    n_checks++; if (bus.o_req_ready !== 2'b01) $display("FAIL b2b_ready1 actual=%b expected=01", bus.o_req_ready); else n_pass++;
    @(posedge clk); #1;
    set_req(0, XOR, 32'hF0, 32'hFF, 4'd6);
    @(negedge clk);
    n_checks++; if (bus.o_req_ready !== 2'b01) $display("FAIL b2b_ready2 actual=%b expected=01", bus.o_req_ready); else n_pass++;
    n_checks++; if ({bus.o_rsp_valid[0], bus.o_rsp_data[0]} !== {1'b1, 32'd7}) $display("FAIL b2b_rsp1 actual=%h expected=100000007", {bus.o_rsp_valid[0], bus.o_rsp_data[0]}); else n_pass++;
    @(posedge clk); #1;
    bus.i_req_valid = 2'b00;
    @(negedge clk);
    n_checks++; if ({bus.o_rsp_valid[0], bus.o_rsp_data[0], bus.o_rsp_tag[0]} !== {1'b1, 32'h0F, 4'd6}) $display("FAIL b2b_rsp2 actual=%h expected=10000000f6", {bus.o_rsp_valid[0], bus.o_rsp_data[0], bus.o_rsp_tag[0]}); else n_pass++;
  endtask

  task automatic test_reset_midop();
    do_reset();
    set_req(1, ADD, 32'd1, 32'd2, 4'd7);
    @(posedge clk); #1;
    bus.i_req_valid[1] = 1'b0;
    set_req(0, OR, 32'h3, 32'h4, 4'd8);
    @(negedge clk);
    n_checks++; if ({bus.o_rsp_valid, bus.o_req_ready} !== 4'b1001) $display("FAIL midrst_pre actual=%b expected=1001", {bus.o_rsp_valid, bus.o_req_ready}); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.o_rsp_valid !== 2'b00) $display("FAIL midrst_rsp_valid actual=%b expected=00", bus.o_rsp_valid); else n_pass++;
    set_req(1, AND, 32'hF, 32'h3, 4'd9);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.o_req_ready !== 2'b01) $display("FAIL midrst_first_grant actual=%b expected=01", bus.o_req_ready); else n_pass++;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_unchecked_opcode();
    do_reset();
    bus.i_rsp_ready = 2'b10;
    set_req(1, 4'd12, 32'd1, 32'd1, 4'd9);
    @(posedge clk); #1;
    bus.i_req_valid = 2'b00;
    @(negedge clk);
    n_checks++; if ({bus.o_rsp_valid[1], bus.o_rsp_data[1], bus.o_rsp_tag[1]} !== {1'b1, 32'd0, 4'd9}) $display("FAIL op12_rsp actual=%h expected=1000000009", {bus.o_rsp_valid[1], bus.o_rsp_data[1], bus.o_rsp_tag[1]}); else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0]  g;
    logic [31:0] ea;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++)
        if (!bus.i_req_valid[p] && $urandom_range(0, 3) != 0) set_rand_req(p);
      bus.i_rsp_ready = 2'($urandom);
      g = model_grant(bus.i_req_valid, bus.i_rsp_ready);
      @(negedge clk);
      n_checks++; if (bus.o_req_ready !== g) $display("FAIL rnd_ready cycle=%0d actual=%b expected=%b", c, bus.o_req_ready, g); else n_pass++;
      ea = g[1] ? bus.i_req_operand_a[1] : (g[0] ? bus.i_req_operand_a[0] : 32'd0);
      n_checks++; if (alu_a !== ea) $display("FAIL rnd_alu_a cycle=%0d actual=%h expected=%h", c, alu_a, ea); else n_pass++;
      for (int p = 0; p < 2; p++) begin
        n_checks++; if (bus.o_rsp_valid[p] !== m_valid[p]) $display("FAIL rnd_rsp_valid port=%0d actual=%b expected=%b", p, bus.o_rsp_valid[p], m_valid[p]); else n_pass++;
        if (m_valid[p]) begin
          n_checks++; if ({bus.o_rsp_data[p], bus.o_rsp_tag[p]} !== {m_data[p], m_tag[p]})
            $display("FAIL rnd_rsp_payload port=%0d actual=%h expected=%h", p, {bus.o_rsp_data[p], bus.o_rsp_tag[p]}, {m_data[p], m_tag[p]}); else n_pass++;
        end
      end
      @(posedge clk);
      for (int p = 0; p < 2; p++) begin
        if (g[p]) begin
          m_valid[p] = 1'b1;
          m_data[p]  = alu_ref(bus.i_req_alu_op[p], bus.i_req_operand_a[p], bus.i_req_operand_b[p]);
          m_tag[p]   = bus.i_req_tag[p];
        end else if (m_valid[p] && bus.i_rsp_ready[p]) begin
          m_valid[p] = 1'b0;
        end
      end
      if (g != 2'b00) m_last = g[1] ? 1 : 0;
      #1;
      for (int p = 0; p < 2; p++) if (g[p]) bus.i_req_valid[p] = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_round_robin();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    test_unchecked_opcode();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
